instr_mem_loader: RTL and testbench

Byte-stream program loader that writes 32-bit instruction words into the instruction memory before the core runs. It accepts bytes over a valid/ready handshake and assembles them little-endian into words. It issues one write per word to the memory's write port, at consecutive word-aligned byte addresses starting from 0. It sits between the host/UART byte source and the instruction memory, and holds the core off while loading.

---
 rtl/instr_mem_loader_if.sv | 31 +++
 rtl/instr_mem_loader.sv | 147 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
//   Bundles the loader's byte-stream handshake and the instruction-memory
//   write port.
//   Byte stream : in_valid, in_data[7:0], in_last (source -> loader),
//                 in_ready (loader -> source)
//   Memory port : mem_we, mem_addr[AW-1:0], mem_wd[31:0] (loader -> memory)
//   master modport: the byte source / memory side (testbench, host).
//   slave  modport: the loader itself.
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int AW = 32
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wd
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Assembles a little-endian byte stream into 32-bit instruction words and
//   writes them to instruction memory at byte addresses 0, 4, 8, ...
//   Holds the core off (busy) while loading.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     start_i       : one-cycle pulse starting a session (IDLE/DONE only)
//     bus           : byte stream + memory write port (slave modport)
//     busy_o        : high while loading/writing
//     done_o        : session finished (normally or by overflow)
//     err_o         : overflow, sticky until next start or reset
//     word_count_o  : words written in this session
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int  DEPTH = 1024,
    parameter int  AW    = 32,
    localparam int WCW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    instr_mem_loader_if.slave  bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [WCW-1:0]     word_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      idx_q;
    logic [31:0]     asm_q;
    logic            last_q;     // word being written carried in_last
    logic [WCW-1:0]  wc_q;
    logic            err_q;
    logic            in_ready_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_wd_q;
    logic            busy_q;
    logic            done_q;

    logic            accept;
    logic [31:0]     word_d;

    // in_ready_q is only ever high in LOAD, so it doubles as the state qualifier.
    always_comb begin
        accept = bus.in_valid && in_ready_q;
        word_d = asm_q;
        word_d[{idx_q, 3'b000} +: 8] = bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            asm_q      <= '0;
            last_q     <= 1'b0;
            wc_q       <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_LOAD;
                        idx_q      <= '0;
                        asm_q      <= '0;
                        last_q     <= 1'b0;
                        wc_q       <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (wc_q == WCW'(DEPTH)) begin
                            // Memory already full: drop the byte, flag, stop.
                            state_q    <= S_DONE;
                            err_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else if (idx_q == 2'd3 || bus.in_last) begin
                            // Unfilled upper bytes of a short word stay 0
                            // because asm_q was cleared after the last write.
                            state_q    <= S_WRITE;
                            in_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= AW'({wc_q, 2'b00});
                            mem_wd_q   <= word_d;
                            last_q     <= bus.in_last;
                        end else begin
                            asm_q <= word_d;
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    wc_q     <= wc_q + 1'b1;
                    idx_q    <= '0;
                    asm_q    <= '0;
                    if (last_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wd    = mem_wd_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign word_count_o  = wc_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed sessions against a loader with a 2-word memory. A reference
//   model turns each session's byte list into the expected write list; a
//   negedge monitor checks every write and the handshake rules each cycle.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;
    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int WCW   = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           busy, done, err;
    logic [WCW-1:0] wc;

    instr_mem_loader_if #(.AW(AW)) bus ();

    instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .bus          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .word_count_o (wc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wd[$];
    int          exp_wc;
    bit          exp_err;
    int          base;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected event", nm);
    endtask

    // Reference: bytes packed 4 per word little-endian (short final word
    // zero-padded), at most DEPTH words; any byte beyond that is overflow.
    task automatic build_model();
        int          n;
        int          i;
        int          w;
        int          k;
        logic [31:0] word;
        n = stim_q.size();
        i = 0;
        w = 0;
        exp_err = 1'b0;
        exp_addr_q.delete();
        exp_wd_q.delete();
        while (i < n) begin
            if (w == DEPTH) begin
                exp_err = 1'b1;
                break;
            end
            word = 32'h0;
            k = 0;
            while (k < 4 && i < n) begin
                word[8*k +: 8] = stim_q[i];
                i++;
                k++;
            end
            exp_addr_q.push_back(32'(w * 4));
            exp_wd_q.push_back(word);
            w++;
        end
        exp_wc = w;
    endtask

    // Per-cycle monitor.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", 32'(bus.in_ready), 32'(busy && !bus.mem_we));
            chk("busy_done_excl", 32'(busy && done), 32'h0);
            if (bus.mem_we) begin
                log_addr.push_back(bus.mem_addr);
                log_wd.push_back(bus.mem_wd);
                if (exp_addr_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    chk("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
                    chk("mem_wd", bus.mem_wd, exp_wd_q.pop_front());
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_in_ready", 32'(bus.in_ready), 32'h1);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_done_clr", 32'(done), 32'h0);
        chk("start_err_clr", 32'(err), 32'h0);
        chk("start_wc_clr", 32'(wc), 32'h0);
    endtask

    // Feeds stim_q; in_last on the final byte. poke = byte index at which a
    // start pulse is raised while loading. Stops early once done is seen.
    task automatic send(input bit gaps, input int poke);
        int n;
        int g;
        int cnt;
        bit acc;
        bit stop;
        n = stim_q.size();
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'($urandom_range(0, 1));
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            bus.in_last  = (i == n - 1);
            if (i == poke) start = 1'b1;
            acc = 1'b0;
            cnt = 0;
            while (!acc && !stop) begin
                @(negedge clk);
                acc = bus.in_ready;
                if (!acc && done) stop = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                cnt++;
                if (!acc && !stop && cnt > 50) begin
                    fail_now("byte_accept_timeout");
                    stop = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) fail_now("done_timeout");
        chk("done", 32'(done), 32'h1);
        chk("err", 32'(err), 32'(exp_err));
        chk("word_count", 32'(wc), 32'(exp_wc));
        chk("writes_pending", 32'(exp_addr_q.size()), 32'h0);
    endtask

    task automatic session(input bit gaps, input int poke);
        build_model();
        base = log_wd.size();
        pulse_start();
        send(gaps, poke);
        wait_done();
    endtask

    task automatic load_two_words();
        stim_q = '{8'h13, 8'h03, 8'hA0, 8'h02, 8'h93, 8'h03, 8'h40, 8'h06};
    endtask

    task automatic pin_two_words();
        chk("two_nwrites", 32'(log_wd.size() - base), 32'h2);
        if (log_wd.size() - base == 2) begin
            chk("two_a0", log_addr[base],   32'h0);
            chk("two_d0", log_wd[base],     32'h02A00313);
            chk("two_a1", log_addr[base+1], 32'h4);
            chk("two_d1", log_wd[base+1],   32'h06400393);
        end
        chk("two_wc", 32'(wc), 32'h2);
        chk("two_err", 32'(err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wc", 32'(wc), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'h0);

        // Two full words from IDLE
        load_two_words();
        session(1'b0, -1);
        pin_two_words();

        // Same stream with source gaps, start pulsed mid-load, restart from DONE
        load_two_words();
        session(1'b1, 2);
        pin_two_words();

        // Overflow: 12 bytes into a 2-word memory
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        session(1'b0, -1);
        chk("ovf_nwrites", 32'(log_wd.size() - base), 32'h2);
        if (log_wd.size() - base == 2) begin
            chk("ovf_a1", log_addr[base+1], 32'h4);
            chk("ovf_d1", log_wd[base+1], 32'h08070605);
        end
        chk("ovf_err", 32'(err), 32'h1);
        chk("ovf_done", 32'(done), 32'h1);
        chk("ovf_wc", 32'(wc), 32'h2);

        // Partial final word, restarting from an errored DONE
        stim_q = '{8'hAA, 8'hBB, 8'hCC};
        session(1'b0, -1);
        chk("part_nwrites", 32'(log_wd.size() - base), 32'h1);
        if (log_wd.size() - base == 1) begin
            chk("part_a0", log_addr[base], 32'h0);
            chk("part_d0", log_wd[base], 32'h00CCBBAA);
        end
        chk("part_wc", 32'(wc), 32'h1);
        chk("part_err", 32'(err), 32'h0);

        // Reset mid-word: two bytes in, then asynchronous reset
        stim_q.delete();
        build_model();
        base = log_wd.size();
        pulse_start();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(posedge clk); #1 bus.in_data = 8'h66;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        chk("arst_mem_wd", bus.mem_wd, 32'h0);
        chk("arst_wc", 32'(wc), 32'h0);
        chk("arst_nwrites", 32'(log_wd.size() - base), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        session(1'b0, -1);
        chk("post_nwrites", 32'(log_wd.size() - base), 32'h1);
        if (log_wd.size() - base == 1) begin
            chk("post_a0", log_addr[base], 32'h0);
            chk("post_d0", log_wd[base], 32'h44332211);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
